// File: rtl/abc_pkg.sv
// Shared types and constants for the a/b/c sequence monitor.
package abc_pkg;

  // Monitor FSM states; the encoding is visible on the phase output.
  typedef enum logic [2:0] {
    START = 3'd0,
    MON_A = 3'd1,
    MON_B = 3'd2,
    MON_C = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } mon_state_t;

  // First-violation cause reported on err_code.
  typedef enum logic [2:0] {
    NONE      = 3'd0,
    BAD_START = 3'd1,
    ILLEGAL   = 3'd2,
    STALL     = 3'd3,
    OVERRUN   = 3'd4,
    POST_DONE = 3'd5
  } mon_err_t;

  // Classification of one counter's current sample against its previous one.
  typedef enum logic [2:0] {
    HOLD_AT_LAST = 3'd0,
    HOLD_EARLY   = 3'd1,
    INC_OK       = 3'd2,
    INC_OVER     = 3'd3,
    BAD          = 3'd4
  } step_t;

  localparam int A_LAST_DEF = 5;
  localparam int B_LAST_DEF = 6;
  localparam int C_LAST_DEF = 7;

  localparam int          CNT_W   = 5;
  localparam logic [4:0]  CNT_MAX = 5'd31;

  // Saturating increment for the evaluated-cycle counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + 5'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/abc_step_check.sv
// Combinational classifier: how a counter moved relative to its previous
// sample and its final value. One instance per counter.
module abc_step_check
  import abc_pkg::*;
#(
  parameter int W = 3
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] prev,
  input  logic [W-1:0] last,
  output step_t        step
);

  logic [W-1:0] prev_inc_s;
  logic         same_s;
  logic         inc_s;
  logic         at_last_s;
  logic         below_s;

  // prev+1 wraps modulo 2^W, so a step from all-ones to zero counts as +1.
  assign prev_inc_s = prev + W'(1'b1);
  assign same_s     = (cur == prev);
  assign inc_s      = (cur == prev_inc_s);
  assign at_last_s  = (prev == last);
  assign below_s    = (prev < last);

  // Classify the step; anything not a legal hold or +1 is BAD.
  always_comb begin
    step = BAD;
    if (same_s) begin
      if (at_last_s) begin
        step = HOLD_AT_LAST;
      end else if (below_s) begin
        step = HOLD_EARLY;
      end else begin
        step = BAD;
      end
    end else if (inc_s) begin
      if (at_last_s) begin
        step = INC_OVER;
      end else if (below_s) begin
        step = INC_OK;
      end else begin
        step = BAD;
      end
    end else begin
      step = BAD;
    end
  end

endmodule

// File: rtl/abc_seq_monitor.sv
// Downstream checker for the three-phase a/b/c counter: follows the
// expected phase order, latches the first violation and reports completion.
module abc_seq_monitor
  import abc_pkg::*;
#(
  parameter int W      = 3,
  parameter int A_LAST = A_LAST_DEF,
  parameter int B_LAST = B_LAST_DEF,
  parameter int C_LAST = C_LAST_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [2:0]   phase,
  output logic         done,
  output logic         err,
  output logic [2:0]   err_code,
  output logic [4:0]   cycle_cnt,
  output logic [4:0]   err_cycle
);

  mon_state_t       state_r;
  mon_state_t       state_s;
  mon_state_t       adv_state_s;
  mon_err_t         viol_s;
  mon_err_t         err_code_r;
  step_t            step_a_s;
  step_t            step_b_s;
  step_t            step_c_s;
  step_t            act_step_s;
  logic             inactive_chg_s;
  logic [W-1:0]     prev_a_r;
  logic [W-1:0]     prev_b_r;
  logic [W-1:0]     prev_c_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [CNT_W-1:0] err_cycle_r;
  logic             done_r;
  logic             err_r;

  abc_step_check #(.W(W)) u_step_a (
    .cur  (a),
    .prev (prev_a_r),
    .last (W'(A_LAST)),
    .step (step_a_s)
  );

  abc_step_check #(.W(W)) u_step_b (
    .cur  (b),
    .prev (prev_b_r),
    .last (W'(B_LAST)),
    .step (step_b_s)
  );

  abc_step_check #(.W(W)) u_step_c (
    .cur  (c),
    .prev (prev_c_r),
    .last (W'(C_LAST)),
    .step (step_c_s)
  );

  // Pick the active counter's step result, the inactive-change flag and the phase that follows.
  always_comb begin
    act_step_s     = BAD;
    inactive_chg_s = 1'b0;
    adv_state_s    = DONE;
    case (state_r)
      MON_A: begin
        act_step_s     = step_a_s;
        inactive_chg_s = (b != prev_b_r) || (c != prev_c_r);
        adv_state_s    = MON_B;
      end
      MON_B: begin
        act_step_s     = step_b_s;
        inactive_chg_s = (a != prev_a_r) || (c != prev_c_r);
        adv_state_s    = MON_C;
      end
      MON_C: begin
        act_step_s     = step_c_s;
        inactive_chg_s = (a != prev_a_r) || (b != prev_b_r);
        adv_state_s    = DONE;
      end
      default: begin
        act_step_s     = BAD;
        inactive_chg_s = 1'b0;
        adv_state_s    = DONE;
      end
    endcase
  end

  // Next-state and violation decode; inactive-counter changes outrank active-counter errors.
  always_comb begin
    state_s = state_r;
    viol_s  = NONE;
    case (state_r)
      START: begin
        if ((a == '0) && (b == '0) && (c == '0)) begin
          state_s = MON_A;
        end else begin
          state_s = ERR;
          viol_s  = BAD_START;
        end
      end
      MON_A, MON_B, MON_C: begin
        if (inactive_chg_s) begin
          state_s = ERR;
          viol_s  = ILLEGAL;
        end else begin
          case (act_step_s)
            HOLD_AT_LAST: state_s = adv_state_s;
            INC_OK:       state_s = state_r;
            HOLD_EARLY: begin
              state_s = ERR;
              viol_s  = STALL;
            end
            INC_OVER: begin
              state_s = ERR;
              viol_s  = OVERRUN;
            end
            default: begin
              state_s = ERR;
              viol_s  = ILLEGAL;
            end
          endcase
        end
      end
      DONE: begin
        if ((a != prev_a_r) || (b != prev_b_r) || (c != prev_c_r)) begin
          state_s = ERR;
          viol_s  = POST_DONE;
        end else begin
          state_s = DONE;
        end
      end
      ERR: begin
        state_s = ERR;
      end
      default: begin
        state_s = ERR;
        viol_s  = ILLEGAL;
      end
    endcase
  end

  // Evaluated-cycle count advances only while the sequence is still being checked.
  always_comb begin
    cnt_s = cnt_r;
    case (state_r)
      START, MON_A, MON_B, MON_C: cnt_s = sat_inc(cnt_r);
      default:                    cnt_s = cnt_r;
    endcase
  end

  // State, previous samples, counters and latched error info; reset wins over every check.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= START;
      prev_a_r    <= '0;
      prev_b_r    <= '0;
      prev_c_r    <= '0;
      cnt_r       <= 5'd0;
      err_code_r  <= NONE;
      err_cycle_r <= 5'd0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r  <= state_s;
      prev_a_r <= a;
      prev_b_r <= b;
      prev_c_r <= c;
      cnt_r    <= cnt_s;
      done_r   <= (state_s == DONE);
      err_r    <= (state_s == ERR);
      // viol_s is only ever raised outside ERR, so this captures the first violation only.
      if (viol_s != NONE) begin
        err_code_r  <= viol_s;
        err_cycle_r <= cnt_s;
      end else begin
        err_code_r  <= err_code_r;
        err_cycle_r <= err_cycle_r;
      end
    end
  end

  assign phase     = state_r;
  assign done      = done_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign cycle_cnt = cnt_r;
  assign err_cycle = err_cycle_r;

endmodule

// File: tb/tb_abc_seq_monitor.sv
// Randomized bench for abc_seq_monitor against a rule-level reference model.
module tb_abc_seq_monitor;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] a, b, c;
  logic [2:0]   phase;
  logic         done, err;
  logic [2:0]   err_code;
  logic [4:0]   cycle_cnt, err_cycle;

  int lim [3] = '{5, 6, 7};

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: phase index 0=start, 1..3=monitoring a/b/c, 4=done, 5=error.
  int m_p, m_cnt, m_code, m_ecyc;
  int m_prev [3];

  abc_seq_monitor #(.W(W), .A_LAST(5), .B_LAST(6), .C_LAST(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .c         (c),
    .phase     (phase),
    .done      (done),
    .err       (err),
    .err_code  (err_code),
    .cycle_cnt (cycle_cnt),
    .err_cycle (err_cycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_cnt = 0; m_code = 0; m_ecyc = 0;
    m_prev = '{0, 0, 0};
  endtask

  task automatic model_fail(input int code);
    m_p    = 5;
    m_code = code;
    m_ecyc = m_cnt;
  endtask

  task automatic model_step(input int va, input int vb, input int vc);
    int  v [3];
    int  k;
    bit  other_moved;
    v = '{va, vb, vc};
    if (m_p <= 3 && m_cnt < 31) m_cnt++;
    if (m_p == 0) begin
      if (va == 0 && vb == 0 && vc == 0) m_p = 1;
      else model_fail(1);
    end else if (m_p >= 1 && m_p <= 3) begin
      k = m_p - 1;
      other_moved = 1'b0;
      for (int j = 0; j < 3; j++)
        if (j != k && v[j] != m_prev[j]) other_moved = 1'b1;
      if (other_moved) model_fail(2);
      else if (v[k] == m_prev[k]) begin
        if (m_prev[k] == lim[k]) m_p++;
        else if (m_prev[k] < lim[k]) model_fail(3);
        else model_fail(2);
      end else if (v[k] == (m_prev[k] + 1) % 8) begin
        if (m_prev[k] == lim[k]) model_fail(4);
        else if (m_prev[k] > lim[k]) model_fail(2);
      end else model_fail(2);
    end else if (m_p == 4) begin
      if (v[0] != m_prev[0] || v[1] != m_prev[1] || v[2] != m_prev[2]) model_fail(5);
    end
    m_prev = v;
  endtask

  // Legal counter value k at edge e (edge 1 = first edge after reset).
  function automatic int gold(input int e, input int k);
    int base [3];
    base = '{1, lim[0] + 2, lim[0] + lim[1] + 3};
    if (e <= base[k]) return 0;
    else if (e - base[k] > lim[k]) return lim[k];
    else return e - base[k];
  endfunction

  task automatic edge_cyc(input bit rst, input int va, input int vb, input int vc);
    @(negedge clk);
    reset = rst;
    a = 3'(va); b = 3'(vb); c = 3'(vc);
    if (rst) model_reset();
    else model_step(va, vb, vc);
    @(posedge clk);
    #1;
    chk("phase",     phase,     m_p);
    chk("done",      done,      (m_p == 4) ? 1 : 0);
    chk("err",       err,       (m_p == 5) ? 1 : 0);
    chk("err_code",  err_code,  m_code);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("err_cycle", err_cycle, m_ecyc);
  endtask

  // Golden sequence of len edges with one optional corrupted sample and optional mid-run reset.
  // ov_mode: 0 = force ov_val, 1 = golden+1 (mod 8), 2 = repeat previous golden value.
  task automatic run_case(input int len, input int ov_e, input int ov_k, input int ov_mode,
                          input int ov_val, input int rst_e);
    int e;
    int v [3];
    edge_cyc(1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    edge_cyc(1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    e = 0;
    for (int i = 1; i <= len; i++) begin
      if (rst_e != 0 && i == rst_e) begin
        edge_cyc(1'b1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        e = 0;
      end else begin
        e++;
        for (int k = 0; k < 3; k++) v[k] = gold(e, k);
        if (e == ov_e) begin
          case (ov_mode)
            0:       v[ov_k] = ov_val;
            1:       v[ov_k] = (gold(e, ov_k) + 1) % 8;
            default: v[ov_k] = gold(e - 1, ov_k);
          endcase
        end
        edge_cyc(1'b0, v[0], v[1], v[2]);
      end
    end
  endtask

  task automatic end_expect(input int code, input int ecyc, input int dn);
    chk("end_err_code",  err_code,  code);
    chk("end_err_cycle", err_cycle, ecyc);
    chk("end_done",      done,      dn);
    chk("end_err",       err,       (code != 0) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; c = '0;
    model_reset();

    // Golden run plus 10 stable cycles.
    run_case(32, 0, 0, 0, 0, 0);
    end_expect(0, 0, 1);
    chk("golden_cnt",   cycle_cnt, 22);
    chk("golden_phase", phase,     4);

    // a=2 at reset release.
    run_case(4, 1, 0, 0, 2, 0);
    end_expect(1, 1, 0);

    // a jumps 3 -> 5 at edge 5.
    run_case(8, 5, 0, 0, 5, 0);
    end_expect(2, 5, 0);

    // b moves to 1 at edge 3 while a is active.
    run_case(6, 3, 1, 0, 1, 0);
    end_expect(2, 3, 0);

    // a held at 3 on edges 4 and 5.
    run_case(8, 5, 0, 0, 3, 0);
    end_expect(3, 5, 0);

    // a steps 5 -> 6 at edge 7 instead of holding.
    run_case(10, 7, 0, 0, 6, 0);
    end_expect(4, 7, 0);

    // c wraps 7 -> 0 at edge 22: counts as +1 past the last value.
    run_case(24, 22, 2, 1, 0, 0);
    end_expect(4, 22, 0);

    // c forced to 0 three cycles after DONE.
    run_case(28, 25, 2, 0, 0, 0);
    end_expect(5, 22, 0);

    // Reset mid-MON_B, then a full golden run.
    run_case(35, 0, 0, 0, 0, 10);
    end_expect(0, 0, 1);
    chk("rst_cnt", cycle_cnt, 22);

    // Randomized corruptions and resets.
    for (int t = 0; t < 40; t++) begin
      int len, oe, ok, om, ov, re;
      len = $urandom_range(20, 34);
      oe  = $urandom_range(0, 30);
      ok  = $urandom_range(0, 2);
      om  = $urandom_range(0, 2);
      ov  = $urandom_range(0, 7);
      re  = ($urandom_range(0, 4) == 0) ? $urandom_range(2, len) : 0;
      run_case(len, oe, ok, om, ov, re);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
